// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, RV64I opcodes and immediate formats for the decode stage
package decode_pkg;
    localparam int XLEN = 64;
    localparam int RA_W = 6;
    localparam logic [6:0] LOAD      = 7'h03;
    localparam logic [6:0] STORE     = 7'h23;
    localparam logic [6:0] BRANCH    = 7'h63;
    localparam logic [6:0] JAL       = 7'h6f;
    localparam logic [6:0] JALR      = 7'h67;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP        = 7'h33;
    localparam logic [6:0] LUI       = 7'h37;
    localparam logic [6:0] AUIPC     = 7'h17;
    localparam logic [6:0] OP_IMM_32 = 7'h1b;
    localparam logic [6:0] OP_32     = 7'h3b;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;
    function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
        return (op == LOAD || op == JALR || op == OP_IMM || op == OP_IMM_32) ? IMM_I :
               op == STORE ? IMM_S :
               op == BRANCH ? IMM_B :
               (op == LUI || op == AUIPC) ? IMM_U :
               op == JAL ? IMM_J : IMM_NONE;
    endfunction
endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational sign-extended immediate for an RV64I instruction word
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    imm_fmt_t fmt;
    always_comb begin
        fmt = imm_fmt(instr[6:0]);
        case (fmt)
            IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV64I decode with load-use stall and ID/EX register; DECODE_WB_BYPASS_EN adds the writeback bypass mux
module decode_stage
    import decode_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            InstrValid,
    input  logic [31:0]     Instr,
    input  logic [XLEN-1:0] InstrPC,
    output logic            InstrReady,
    output logic [RA_W-1:0] Read1,
    output logic [RA_W-1:0] Read2,
    input  logic [XLEN-1:0] Data1,
    input  logic [XLEN-1:0] Data2,
    input  logic            WbRegWrite,
    input  logic [RA_W-1:0] WbReg,
    input  logic [XLEN-1:0] WbData,
    input  logic            Flush,
    input  logic            ExReady,
    output logic            ExValid,
    output logic [XLEN-1:0] ExPC,
    output logic [XLEN-1:0] ExRs1Val,
    output logic [XLEN-1:0] ExRs2Val,
    output logic [XLEN-1:0] ExImm,
    output logic [RA_W-1:0] ExRs1,
    output logic [RA_W-1:0] ExRs2,
    output logic [RA_W-1:0] ExRd,
    output logic [6:0]      ExOpcode,
    output logic [2:0]      ExFunct3,
    output logic [6:0]      ExFunct7,
    output logic            ExMemRead,
    output logic            ExMemWrite,
    output logic            ExRegWrite
);
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, hit1, hit2, known, reg_write;
    logic load_use, wb_stall, stall, advance, take;
    logic [XLEN-1:0] op1, op2, imm;

    assign opcode = Instr[6:0];
    assign rs1 = Instr[19:15];
    assign rs2 = Instr[24:20];
    assign rd = Instr[11:7];
    assign Read1 = {1'b0, rs1};
    assign Read2 = {1'b0, rs2};
    assign use1 = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
    assign use2 = opcode == OP || opcode == OP_32 || opcode == STORE || opcode == BRANCH;
    assign hit1 = WbRegWrite && WbReg == Read1 && rs1 != '0;
    assign hit2 = WbRegWrite && WbReg == Read2 && rs2 != '0;

`ifdef DECODE_WB_BYPASS_EN
    assign op1 = rs1 == '0 ? '0 : hit1 ? WbData : Data1;
    assign op2 = rs2 == '0 ? '0 : hit2 ? WbData : Data2;
    assign wb_stall = 1'b0;
`else
    // without the mux, a landing write is picked up by re-reading the register file next cycle
    logic unused_wb;
    assign unused_wb = ^WbData;
    assign op1 = rs1 == '0 ? '0 : Data1;
    assign op2 = rs2 == '0 ? '0 : Data2;
    assign wb_stall = (use1 && hit1) || (use2 && hit2);
`endif

    assign load_use = ExValid && ExMemRead && ExRd != '0 &&
                      ((use1 && Read1 == ExRd) || (use2 && Read2 == ExRd));
    assign stall = load_use || wb_stall;
    assign advance = !ExValid || ExReady;
    assign take = advance && InstrValid && !stall;
    assign InstrReady = Flush || (advance && !stall);
    assign known = opcode inside {LOAD, STORE, BRANCH, JAL, JALR, OP_IMM, OP, LUI, AUIPC, OP_IMM_32, OP_32};
    assign reg_write = known && opcode != STORE && opcode != BRANCH && rd != '0;

    imm_gen u_imm_gen (.instr(Instr), .imm(imm));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ExValid <= 1'b0;
            ExPC <= '0;
            ExRs1Val <= '0;
            ExRs2Val <= '0;
            ExImm <= '0;
            ExRs1 <= '0;
            ExRs2 <= '0;
            ExRd <= '0;
            ExOpcode <= '0;
            ExFunct3 <= '0;
            ExFunct7 <= '0;
            ExMemRead <= 1'b0;
            ExMemWrite <= 1'b0;
            ExRegWrite <= 1'b0;
        end else if (Flush) begin
            ExValid <= 1'b0;
        end else if (take) begin
            ExValid <= 1'b1;
            ExPC <= InstrPC;
            ExRs1Val <= op1;
            ExRs2Val <= op2;
            ExImm <= imm;
            ExRs1 <= Read1;
            ExRs2 <= Read2;
            ExRd <= {1'b0, rd};
            ExOpcode <= opcode;
            ExFunct3 <= Instr[14:12];
            ExFunct7 <= Instr[31:25];
            ExMemRead <= opcode == LOAD;
            ExMemWrite <= opcode == STORE;
            ExRegWrite <= reg_write;
        end else if (advance) begin
            ExValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized cycle model for decode_stage
module tb_decode_stage;
    import decode_pkg::*;

    logic clock, reset_n, InstrValid, InstrReady, WbRegWrite, Flush, ExReady;
    logic [31:0] Instr;
    logic [XLEN-1:0] InstrPC, Data1, Data2, WbData;
    logic [RA_W-1:0] Read1, Read2, WbReg;
    logic ExValid, ExMemRead, ExMemWrite, ExRegWrite;
    logic [XLEN-1:0] ExPC, ExRs1Val, ExRs2Val, ExImm;
    logic [RA_W-1:0] ExRs1, ExRs2, ExRd;
    logic [6:0] ExOpcode, ExFunct7;
    logic [2:0] ExFunct3;

    typedef struct packed {
        logic v;
        logic [63:0] pc, a, b, imm;
        logic [5:0] rs1, rs2, rd;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic mr, mw, rw;
    } ex_t;

    ex_t ex_all;
    logic [XLEN-1:0] rf [32];
    int total = 0;
    int passed = 0;

    decode_stage dut (
        .clock(clock), .reset_n(reset_n), .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
        .InstrReady(InstrReady), .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
        .WbRegWrite(WbRegWrite), .WbReg(WbReg), .WbData(WbData), .Flush(Flush), .ExReady(ExReady),
        .ExValid(ExValid), .ExPC(ExPC), .ExRs1Val(ExRs1Val), .ExRs2Val(ExRs2Val), .ExImm(ExImm),
        .ExRs1(ExRs1), .ExRs2(ExRs2), .ExRd(ExRd), .ExOpcode(ExOpcode), .ExFunct3(ExFunct3),
        .ExFunct7(ExFunct7), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExRegWrite(ExRegWrite)
    );

    assign ex_all = {ExValid, ExPC, ExRs1Val, ExRs2Val, ExImm, ExRs1, ExRs2, ExRd,
                     ExOpcode, ExFunct3, ExFunct7, ExMemRead, ExMemWrite, ExRegWrite};
    assign Data1 = rf[Read1[4:0]];
    assign Data2 = rf[Read2[4:0]];

    always @(posedge clock) if (WbRegWrite) rf[WbReg[4:0]] <= WbData;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

`ifdef DECODE_WB_BYPASS_EN
    localparam int WB_STALLS = 0;
`else
    localparam int WB_STALLS = 1;
`endif

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2, s1, d);
        return {f7, s2, s1, 3'b000, d, OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] im, input logic [4:0] s1,
                                           input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {im, s1, f3, d, op};
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins);
        case (ins[6:0])
            LOAD, JALR, OP_IMM, OP_IMM_32: return 64'($signed(ins[31:20]));
            STORE:      return 64'($signed({ins[31:25], ins[11:7]}));
            BRANCH:     return 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            LUI, AUIPC: return 64'($signed({ins[31:12], 12'h000}));
            JAL:        return 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default:    return 64'd0;
        endcase
    endfunction

    function automatic ex_t ref_capture(input logic [31:0] ins, input logic [63:0] pc, av, bv);
        ex_t e;
        logic [6:0] op;
        op = ins[6:0];
        e.v = 1'b1;
        e.pc = pc;
        e.a = av;
        e.b = bv;
        e.imm = ref_imm(ins);
        e.rs1 = {1'b0, ins[19:15]};
        e.rs2 = {1'b0, ins[24:20]};
        e.rd = {1'b0, ins[11:7]};
        e.op = op;
        e.f3 = ins[14:12];
        e.f7 = ins[31:25];
        e.mr = op == LOAD;
        e.mw = op == STORE;
        e.rw = (op inside {LOAD, JAL, JALR, OP_IMM, OP, LUI, AUIPC, OP_IMM_32, OP_32}) && ins[11:7] != 5'd0;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc, output int stalls);
        InstrValid = 1'b1;
        Instr = ins;
        InstrPC = pc;
        stalls = 0;
        #1;
        while (!InstrReady && stalls < 8) begin
            cyc();
            WbRegWrite = 1'b0;
            stalls++;
            #1;
        end
        total++;
        if (InstrReady !== 1'b1) $display("FAIL issue_timeout ready=%b required=1 instr=%h", InstrReady, ins);
        else passed++;
        cyc();
        InstrValid = 1'b0;
        WbRegWrite = 1'b0;
    endtask

    task automatic test_reset();
        int st;
        reset_n = 1'b1;
        cyc();
        issue(i_type(12'd9, 5'd1, 3'd0, 5'd2, OP_IMM), 64'h40, st);
        total++;
        if (ExValid !== 1'b1) $display("FAIL pre_reset_valid got=%b required=1", ExValid);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (ex_all !== '0) $display("FAIL reset_outputs got=%h required=0", ex_all);
        else passed++;
        total++;
        if (InstrReady !== 1'b1) $display("FAIL reset_ready got=%b required=1", InstrReady);
        else passed++;
        cyc();
        cyc();
        reset_n = 1'b1;
        issue(i_type(12'd5, 5'd0, 3'd0, 5'd1, OP_IMM), 64'h100, st);
        total++;
        if ({ExValid, ExImm, ExPC, ExRd, ExRegWrite, ExRs1Val} !== {1'b1, 64'd5, 64'h100, 6'd1, 1'b1, 64'd0})
            $display("FAIL first_addi got v=%b imm=%h pc=%h rd=%0d rw=%b a=%h required v=1 imm=5 pc=100 rd=1 rw=1 a=0",
                     ExValid, ExImm, ExPC, ExRd, ExRegWrite, ExRs1Val);
        else passed++;
    endtask

    task automatic test_bypass();
        int st;
        WbRegWrite = 1'b1;
        WbReg = 6'd3;
        WbData = 64'h1;
        cyc();
        WbData = 64'hDEAD;
        issue(r_type(7'h00, 5'd3, 5'd3, 5'd4), 64'h200, st);
        total++;
        if ({ExRs1Val, ExRs2Val} !== {64'hDEAD, 64'hDEAD})
            $display("FAIL bypass_operands got a=%h b=%h required dead/dead", ExRs1Val, ExRs2Val);
        else passed++;
        total++;
        if (st != WB_STALLS) $display("FAIL bypass_stalls got=%0d required=%0d", st, WB_STALLS);
        else passed++;
    endtask

    task automatic test_x0();
        int st;
        WbRegWrite = 1'b1;
        WbReg = 6'd0;
        WbData = 64'h55;
        cyc();
        WbRegWrite = 1'b0;
        issue(r_type(7'h00, 5'd0, 5'd0, 5'd5), 64'h208, st);
        total++;
        if ({ExRs1Val, ExRs2Val, ExRegWrite, ExRd} !== {128'd0, 1'b1, 6'd5})
            $display("FAIL x0_operands got a=%h b=%h rw=%b rd=%0d required 0 0 1 5", ExRs1Val, ExRs2Val, ExRegWrite, ExRd);
        else passed++;
    endtask

    task automatic test_load_use();
        int st;
        issue(i_type(12'd0, 5'd2, 3'd3, 5'd6, LOAD), 64'h300, st);
        total++;
        if ({ExMemRead, ExRd} !== {1'b1, 6'd6}) $display("FAIL ld_capture got mr=%b rd=%0d required 1 6", ExMemRead, ExRd);
        else passed++;
        InstrValid = 1'b1;
        Instr = r_type(7'h00, 5'd1, 5'd6, 5'd7);
        InstrPC = 64'h304;
        #1;
        total++;
        if (InstrReady !== 1'b0) $display("FAIL loaduse_stall got=%b required=0", InstrReady);
        else passed++;
        cyc();
        total++;
        if (ExValid !== 1'b0) $display("FAIL loaduse_bubble got=%b required=0", ExValid);
        else passed++;
        #1;
        total++;
        if (InstrReady !== 1'b1) $display("FAIL loaduse_resume got=%b required=1", InstrReady);
        else passed++;
        cyc();
        InstrValid = 1'b0;
        total++;
        if ({ExValid, ExRd, ExPC, ExRs1Val, ExRs2Val} !== {1'b1, 6'd7, 64'h304, rf[6], rf[1]})
            $display("FAIL loaduse_add got v=%b rd=%0d pc=%h a=%h b=%h required 1 7 304 %h %h",
                     ExValid, ExRd, ExPC, ExRs1Val, ExRs2Val, rf[6], rf[1]);
        else passed++;
        issue(i_type(12'd0, 5'd2, 3'd3, 5'd6, LOAD), 64'h308, st);
        InstrValid = 1'b1;
        Instr = {7'h20, 5'd2, 5'd1, 3'd0, 5'd7, OP};
        InstrPC = 64'h30c;
        #1;
        total++;
        if (InstrReady !== 1'b1) $display("FAIL independent_nostall got=%b required=1", InstrReady);
        else passed++;
        cyc();
        InstrValid = 1'b0;
        total++;
        if ({ExValid, ExRd, ExFunct7, ExPC} !== {1'b1, 6'd7, 7'h20, 64'h30c})
            $display("FAIL sub_capture got v=%b rd=%0d f7=%h pc=%h required 1 7 20 30c", ExValid, ExRd, ExFunct7, ExPC);
        else passed++;
        issue(i_type(12'd0, 5'd2, 3'd3, 5'd6, LOAD), 64'h310, st);
        InstrValid = 1'b1;
        Instr = r_type(7'h00, 5'd1, 5'd6, 5'd7);
        #1;
        total++;
        if (InstrReady !== 1'b0) $display("FAIL midstall_pre got=%b required=0", InstrReady);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if ({InstrReady, ExValid, ExMemRead} !== 3'b100)
            $display("FAIL midstall_reset got ready=%b v=%b mr=%b required 1 0 0", InstrReady, ExValid, ExMemRead);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        InstrValid = 1'b0;
    endtask

    task automatic test_backpressure();
        int st;
        ExReady = 1'b1;
        issue(i_type(12'hffd, 5'd0, 3'd0, 5'd8, OP_IMM), 64'h500, st);
        ExReady = 1'b0;
        InstrValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Instr = $urandom;
            InstrPC = {$urandom, $urandom};
            #1;
            total++;
            if (InstrReady !== 1'b0) $display("FAIL bp_ready cycle=%0d got=%b required=0", i, InstrReady);
            else passed++;
            cyc();
            total++;
            if ({ExValid, ExPC, ExImm, ExRd} !== {1'b1, 64'h500, -64'sd3, 6'd8})
                $display("FAIL bp_hold cycle=%0d got v=%b pc=%h imm=%h rd=%0d required 1 500 -3 8", i, ExValid, ExPC, ExImm, ExRd);
            else passed++;
        end
        Instr = r_type(7'h00, 5'd2, 5'd1, 5'd9);
        InstrPC = 64'h504;
        ExReady = 1'b1;
        #1;
        total++;
        if (InstrReady !== 1'b1) $display("FAIL bp_release got=%b required=1", InstrReady);
        else passed++;
        cyc();
        InstrValid = 1'b0;
        total++;
        if ({ExValid, ExPC, ExRd, ExRs1Val} !== {1'b1, 64'h504, 6'd9, rf[1]})
            $display("FAIL bp_next got v=%b pc=%h rd=%0d a=%h required 1 504 9 %h", ExValid, ExPC, ExRd, ExRs1Val, rf[1]);
        else passed++;
    endtask

    task automatic test_flush_imm();
        int st;
        logic [31:0] jal_ins;
        ExReady = 1'b0;
        Flush = 1'b1;
        InstrValid = 1'b1;
        Instr = i_type(12'd1, 5'd0, 3'd0, 5'd10, OP_IMM);
        InstrPC = 64'h600;
        #1;
        total++;
        if (InstrReady !== 1'b1) $display("FAIL flush_ready got=%b required=1", InstrReady);
        else passed++;
        cyc();
        Flush = 1'b0;
        InstrValid = 1'b0;
        total++;
        if (ExValid !== 1'b0) $display("FAIL flush_clear got=%b required=0", ExValid);
        else passed++;
        ExReady = 1'b1;
        cyc();
        total++;
        if (ExValid !== 1'b0) $display("FAIL flush_dropped got=%b required=0", ExValid);
        else passed++;
        issue(32'hFE000EE3, 64'h700, st);
        total++;
        if ({ExImm, ExRegWrite, ExOpcode} !== {-64'sd4, 1'b0, BRANCH})
            $display("FAIL beq_imm got imm=%h rw=%b op=%h required fffffffffffffffc 0 63", ExImm, ExRegWrite, ExOpcode);
        else passed++;
        jal_ins = {1'b1, 10'd0, 1'b1, 8'hff, 5'd1, JAL};
        issue(jal_ins, 64'h704, st);
        total++;
        if ({ExImm, ExRegWrite, ExRd} !== {64'hFFFF_FFFF_FFFF_F800, 1'b1, 6'd1})
            $display("FAIL jal_imm got imm=%h rw=%b rd=%0d required fffffffffffff800 1 1", ExImm, ExRegWrite, ExRd);
        else passed++;
    endtask

    task automatic test_random();
        logic [6:0] ops [11] = '{LOAD, STORE, BRANCH, JAL, JALR, OP_IMM, OP, LUI, AUIPC, OP_IMM_32, OP_32};
        ex_t m;
        logic [4:0] r1, r2;
        logic u1, u2, h1, h2, lu, ws, adv, st, rdy;
        logic [63:0] av, bv;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        m = '0;
        for (int n = 0; n < 500; n++) begin
            Instr = $urandom;
            Instr[6:0] = $urandom_range(0, 15) == 0 ? 7'h7f : ops[$urandom_range(0, 10)];
            Instr[19:15] = 5'($urandom_range(0, 7));
            Instr[24:20] = 5'($urandom_range(0, 7));
            Instr[11:7] = 5'($urandom_range(0, 7));
            InstrPC = {$urandom, $urandom};
            InstrValid = $urandom_range(0, 3) != 0;
            ExReady = $urandom_range(0, 3) != 0;
            Flush = $urandom_range(0, 15) == 0;
            WbRegWrite = $urandom_range(0, 1) == 1;
            WbReg = 6'($urandom_range(0, 7));
            WbData = {$urandom, $urandom};
            #1;
            r1 = Instr[19:15];
            r2 = Instr[24:20];
            u1 = !(Instr[6:0] inside {LUI, AUIPC, JAL});
            u2 = Instr[6:0] inside {OP, OP_32, STORE, BRANCH};
            h1 = WbRegWrite && WbReg == {1'b0, r1} && r1 != 0;
            h2 = WbRegWrite && WbReg == {1'b0, r2} && r2 != 0;
            lu = m.v && m.mr && m.rd != 0 && ((u1 && m.rd == {1'b0, r1}) || (u2 && m.rd == {1'b0, r2}));
`ifdef DECODE_WB_BYPASS_EN
            ws = 1'b0;
            av = r1 == 0 ? 64'd0 : h1 ? WbData : rf[r1];
            bv = r2 == 0 ? 64'd0 : h2 ? WbData : rf[r2];
`else
            ws = (u1 && h1) || (u2 && h2);
            av = r1 == 0 ? 64'd0 : rf[r1];
            bv = r2 == 0 ? 64'd0 : rf[r2];
`endif
            adv = !m.v || ExReady;
            st = lu || ws;
            rdy = Flush || (adv && !st);
            total++;
            if (InstrReady !== rdy) $display("FAIL rnd_ready n=%0d got=%b required=%b", n, InstrReady, rdy);
            else passed++;
            total++;
            if ({Read1, Read2} !== {1'b0, r1, 1'b0, r2})
                $display("FAIL rnd_read n=%0d got=%0d,%0d required=%0d,%0d", n, Read1, Read2, r1, r2);
            else passed++;
            if (Flush) m.v = 1'b0;
            else if (adv && InstrValid && !st) m = ref_capture(Instr, InstrPC, av, bv);
            else if (adv) m.v = 1'b0;
            cyc();
            total++;
            if (ex_all !== m) $display("FAIL rnd_ex n=%0d got=%h required=%h", n, ex_all, m);
            else passed++;
        end
        InstrValid = 1'b0;
        Flush = 1'b0;
        WbRegWrite = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        InstrValid = 1'b0;
        Instr = '0;
        InstrPC = '0;
        Flush = 1'b0;
        ExReady = 1'b1;
        WbRegWrite = 1'b0;
        WbReg = '0;
        WbData = '0;
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            WbRegWrite = 1'b1;
            WbReg = 6'(i);
            WbData = {32'hA5A5_0000, 32'(i * 17 + 3)};
            cyc();
        end
        WbRegWrite = 1'b0;
        test_reset();
        test_bypass();
        test_x0();
        test_load_use();
        test_backpressure();
        test_flush_imm();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
